sr_pulse_driver: RTL and testbench



---
 rtl/sr_pulse_driver.sv | 183 ++++++++++++++++++
 tb/tb_sr_pulse_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: turns valid/ready set/reset commands into fixed-width,
// non-overlapping, registered pulses for a cross-coupled NOR SR latch, then
// inserts a guard gap so the latch can settle before the next command.
//
// Optional build macro SR_RESPONSE_CHECK_EN: synchronises the latch Q/Qbar
// feedback and adds a one-cycle CHECK state that raises a sticky err flag
// when the latch did not take the commanded state.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; a command offered
// while busy stays pending on the inputs until IDLE and is never dropped.
module sr_pulse_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic             cmd_op,
  output logic             cmd_ready,
  output logic             set,
  output logic             reset,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [2:0]       dbg_state
);

  // Zero-width pulses or gaps are meaningless; clamp them to one cycle.
  localparam int PW   = (PULSE_W < 1) ? 1 : PULSE_W;
  localparam int GW   = (GAP_W < 1) ? 1 : GAP_W;
  localparam int TMAX = (PW > GW) ? PW : GW;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] PW_LAST = TW'(PW - 1);
  localparam logic [TW-1:0] GW_LAST = TW'(GW - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             op_q, op_d;
  logic             set_q, set_d;
  logic             reset_q, reset_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SR_RESPONSE_CHECK_EN
  logic [1:0] q_sync_q, q_sync_d;
  logic [1:0] qb_sync_q, qb_sync_d;
  logic       err_q, err_d;

  // Two-flop synchronisers for the asynchronous latch feedback.
  always_comb begin
    q_sync_d  = {q_sync_q[0], q_in};
    qb_sync_d = {qb_sync_q[0], qbar_in};
  end

  // Synchroniser and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync_q  <= 2'b00;
      qb_sync_q <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      q_sync_q  <= q_sync_d;
      qb_sync_q <= qb_sync_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  // Feedback is not observed in this build.
  logic unused_fb;
  assign unused_fb = q_in ^ qbar_in;
  assign err       = 1'b0;
`endif

  // Next-state, timer, captured op and registered-output computation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
`ifdef SR_RESPONSE_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (timer_q == PW_LAST) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == GW_LAST) begin
          timer_d = '0;
`ifdef SR_RESPONSE_CHECK_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef SR_RESPONSE_CHECK_EN
      ST_CHECK: begin
        // Latch must show q == op and qbar == ~op; q == qbar is always wrong.
        if ((q_sync_q[1] != op_q) || (qb_sync_q[1] != !op_q)) begin
          err_d = 1'b1;
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Count on entry to DONE so pulse_cnt updates together with done.
    if (state_d == ST_DONE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they come straight off flops.
    set_d   = (state_d == ST_PULSE) && op_d;
    reset_d = (state_d == ST_PULSE) && !op_d;
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      op_q    <= 1'b0;
      set_q   <= 1'b0;
      reset_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      set_q   <= set_d;
      reset_q <= reset_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign set       = set_q;
  assign reset     = reset_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Testbench for sr_pulse_driver: random command stream, scoreboard queue of
// accepted commands, negedge monitor comparing every cycle against timing
// derived from pulse width, gap width and (optional) check cycle.
module tb_sr_pulse_driver;

  localparam int PULSE_W = 4;
  localparam int GAP_W   = 2;
  localparam int CNT_W   = 2;
`ifdef SR_RESPONSE_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  // Cycles from the accept edge to the done cycle.
  localparam int LAT = PULSE_W + GAP_W + CHK;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_op;
  logic             cmd_ready;
  logic             set;
  logic             reset;
  logic             q_in;
  logic             qbar_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pulse_cnt;
  logic [2:0]       dbg_state;

  sr_pulse_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .set       (set),
    .reset     (reset),
    .q_in      (q_in),
    .qbar_in   (qbar_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pulse_cnt (pulse_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- latch model ----------------
  logic q_m = 1'b0;
  bit   force_q0 = 1'b0;
  always @(set, reset) begin
    if (set) q_m = 1'b1;
    else if (reset) q_m = 1'b0;
  end
  assign q_in    = force_q0 ? 1'b0 : q_m;
  assign qbar_in = ~q_m;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic             op;
    int               acc;
    logic [CNT_W-1:0] cnt;
    logic             bad;
  } exp_t;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               last_done = -1;
  logic [CNT_W-1:0] next_cnt = '0;
  logic [CNT_W-1:0] cnt_model = '0;
  bit               err_exp = 1'b0;
  bit               in_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Accept tracker: a command transfers on an edge when valid and the model
  // says the block has finished its previous command.
  always @(posedge clk) begin
    exp_t e;
    if (!in_rst && cmd_valid && (cyc > last_done)) begin
      next_cnt = next_cnt + 1'b1;
      e.op  = cmd_op;
      e.acc = cyc + 1;
      e.cnt = next_cnt;
      e.bad = (CHK != 0) && force_q0 && cmd_op;
      exp_q.push_back(e);
      last_done = cyc + 1 + LAT;
    end
    cyc++;
  end

  // Monitor: every cycle compare outputs against the head command's timeline.
  always @(negedge clk) begin
    exp_t h;
    bit es, er, ed;
    if (!in_rst) begin
      es = 1'b0; er = 1'b0; ed = 1'b0;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        if (cyc >= h.acc && cyc < h.acc + PULSE_W) begin
          es = h.op;
          er = !h.op;
        end
        if (cyc == h.acc + LAT) begin
          ed = 1'b1;
          cnt_model = h.cnt;
          if (h.bad) err_exp = 1'b1;
          void'(exp_q.pop_front());
        end
      end
      chk("set", 32'(set), 32'(es));
      chk("reset", 32'(reset), 32'(er));
      chk("overlap", 32'(set & reset), 32'd0);
      chk("done", 32'(done), 32'(ed));
      chk("cmd_ready", 32'(cmd_ready), 32'(cyc > last_done));
      chk("busy", 32'(busy), 32'(cyc <= last_done));
      chk("pulse_cnt", 32'(pulse_cnt), 32'(cnt_model));
      chk("err", 32'(err), 32'(err_exp));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the command until it transfers.
  task automatic send(input bit op, input bit keep);
    bit r;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    do begin
      r = cmd_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 200);
    if (!r) begin
      total++;
      bad++;
      $display("FAIL accept_timeout cyc=%0d got=0 want=1", cyc);
    end
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    cmd_op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc <= last_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout cyc=%0d got=%0d want=0", cyc, exp_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    // Asynchronous reset values before any clock edge.
    chk("rst_set", 32'(set), 32'd0);
    chk("rst_reset", 32'(reset), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(pulse_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    in_rst = 1'b0;

    // Idle with no command.
    repeat (5) @(negedge clk);

    // Single set command with default timing.
    send(1'b1, 1'b0);
    wait_idle();

    // Alternating ops with valid held high across commands.
    for (int i = 0; i < 8; i++) begin
      send(i[0] == 1'b0, i != 7);
    end
    wait_idle();

    // Random ops, random spacing, random valid hold; wraps pulse_cnt.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    wait_idle();

    // Latch fails to take a set command; later commands keep err sticky.
    force_q0 = 1'b1;
    send(1'b1, 1'b0);
    repeat (LAT + 2) @(negedge clk);
    force_q0 = 1'b0;
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    wait_idle();

    // Reset asserted in the second cycle of a set pulse.
    send(1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_set", 32'(set), 32'd1);
    in_rst = 1'b1;
    rst_n  = 1'b0;
    exp_q.delete();
    last_done = -1;
    next_cnt  = '0;
    cnt_model = '0;
    err_exp   = 1'b0;
    #1;
    chk("mid_rst_set", 32'(set), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cnt", 32'(pulse_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    in_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    send(1'b0, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
